// File: rtl/ctrl_fsm.sv
// Instruction sequencing controller: captures an opcode, decodes it to a one-hot
// control vector and walks DECODE/EXEC/MEM/WB, producing write strobes and a retire count.
module ctrl_fsm #(
    parameter int OPCODE_W    = 5,
    parameter int CTRL_W      = 11,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_done,
    output logic [CTRL_W-1:0]   ctrl,
    output logic [2:0]          state,
    output logic                rf_we,
    output logic                pc_we,
    output logic                illegal,
    output logic                mem_err,
    output logic [CNT_W-1:0]    retire_cnt
);

    // state  | meaning
    // IDLE   | ready for an opcode, ctrl cleared
    // DECODE | ctrl holds decoded vector; empty vector means illegal opcode
    // EXEC   | branches/jumps retire here; others pick MEM or WB
    // MEM    | wait for mem_done, bounded by the timeout down-counter
    // WB     | register-file write and retire
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } st_t;

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(5'h00);
    localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(5'h01);
    localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(5'h02);
    localparam logic [OPCODE_W-1:0] OP_JAL  = OPCODE_W'(5'h03);
    localparam logic [OPCODE_W-1:0] OP_JR   = OPCODE_W'(5'h04);
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(5'h05);
    localparam logic [OPCODE_W-1:0] OP_BLT  = OPCODE_W'(5'h06);
    localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(5'h07);
    localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(5'h08);
    localparam logic [OPCODE_W-1:0] OP_SETX = OPCODE_W'(5'h15);
    localparam logic [OPCODE_W-1:0] OP_BEX  = OPCODE_W'(5'h16);

    st_t               cur_st, nxt_st;
    logic [CTRL_W-1:0] ctrl_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              is_lw, is_mem, is_wb;

    function automatic logic [CTRL_W-1:0] decode(input logic [OPCODE_W-1:0] op);
        logic [CTRL_W-1:0] v;
        v = '0;
        case (op)
            OP_LW:   v[0]  = 1'b1;
            OP_SW:   v[1]  = 1'b1;
            OP_ADDI: v[2]  = 1'b1;
            OP_ADD:  v[3]  = 1'b1;
            OP_J:    v[4]  = 1'b1;
            OP_BNE:  v[5]  = 1'b1;
            OP_JAL:  v[6]  = 1'b1;
            OP_JR:   v[7]  = 1'b1;
            OP_BLT:  v[8]  = 1'b1;
            OP_BEX:  v[9]  = 1'b1;
            OP_SETX: v[10] = 1'b1;
            default: v     = '0;
        endcase
        return v;
    endfunction

    // Instruction class is read straight from the held one-hot vector.
    assign is_lw  = ctrl[0];
    assign is_mem = ctrl[0] | ctrl[1];
    assign is_wb  = ctrl[2] | ctrl[3] | ctrl[6] | ctrl[10];

    assign state       = cur_st;
    assign instr_ready = (cur_st == ST_IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur_st     <= ST_IDLE;
            ctrl       <= '0;
            wait_cnt   <= '0;
            retire_cnt <= '0;
        end else begin
            cur_st   <= nxt_st;
            ctrl     <= ctrl_nxt;
            wait_cnt <= wait_nxt;
            if (pc_we) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        nxt_st   = cur_st;
        ctrl_nxt = ctrl;
        wait_nxt = wait_cnt;
        rf_we    = 1'b0;
        pc_we    = 1'b0;
        illegal  = 1'b0;
        mem_err  = 1'b0;
        case (cur_st)
            ST_IDLE: begin
                ctrl_nxt = '0;
                if (instr_valid) begin
                    ctrl_nxt = decode(opcode);
                    nxt_st   = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (ctrl == '0) begin
                    illegal = 1'b1;
                    nxt_st  = ST_IDLE;
                end else begin
                    nxt_st = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (is_mem) begin
                    wait_nxt = WAIT_LOAD;
                    nxt_st   = ST_MEM;
                end else if (is_wb) begin
                    nxt_st = ST_WB;
                end else begin
                    pc_we    = 1'b1;
                    ctrl_nxt = '0;
                    nxt_st   = ST_IDLE;
                end
            end
            ST_MEM: begin
                // mem_done wins over a timeout landing in the same cycle
                if (mem_done) begin
                    if (is_lw) begin
                        nxt_st = ST_WB;
                    end else begin
                        pc_we    = 1'b1;
                        ctrl_nxt = '0;
                        nxt_st   = ST_IDLE;
                    end
                end else if (wait_cnt == '0) begin
                    mem_err  = 1'b1;
                    ctrl_nxt = '0;
                    nxt_st   = ST_IDLE;
                end else begin
                    wait_nxt = wait_cnt - WAIT_W'(1);
                end
            end
            ST_WB: begin
                rf_we    = 1'b1;
                pc_we    = 1'b1;
                ctrl_nxt = '0;
                nxt_st   = ST_IDLE;
            end
            default: begin
                ctrl_nxt = '0;
                nxt_st   = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Bench for ctrl_fsm: per-instruction expected traces built from latency rules,
// checked every cycle, plus literal checks on reset and retire counts.
module tb_ctrl_fsm;

    localparam int T = 15;

    logic        clock;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [4:0]  opcode;
    logic        mem_done;
    logic [10:0] ctrl;
    logic [2:0]  state;
    logic        rf_we;
    logic        pc_we;
    logic        illegal;
    logic        mem_err;
    logic [3:0]  retire_cnt;

    ctrl_fsm #(
        .OPCODE_W(5), .CTRL_W(11), .MEM_TIMEOUT(T), .CNT_W(4)
    ) dut (
        .clock(clock), .reset(reset), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .opcode(opcode), .mem_done(mem_done),
        .ctrl(ctrl), .state(state), .rf_we(rf_we), .pc_we(pc_we),
        .illegal(illegal), .mem_err(mem_err), .retire_cnt(retire_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  st;
        logic [10:0] ctrl;
        logic        rf;
        logic        pc;
        logic        ill;
        logic        merr;
        logic        rdy;
        logic [3:0]  rc;
    } rec_t;

    rec_t       q[$];
    logic [3:0] m_retire;
    int         n_run;
    int         n_fail;
    bit         chk_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int bit_of(input logic [4:0] op);
        case (op)
            5'h00: return 3;
            5'h05: return 2;
            5'h07: return 1;
            5'h08: return 0;
            5'h01: return 4;
            5'h02: return 5;
            5'h03: return 6;
            5'h04: return 7;
            5'h06: return 8;
            5'h16: return 9;
            5'h15: return 10;
            default: return -1;
        endcase
    endfunction

    task automatic push(input int st, input logic [10:0] c, input bit rf, input bit pc,
                        input bit ill, input bit merr, input bit rdy);
        rec_t r;
        r.st = 3'(st); r.ctrl = c; r.rf = rf; r.pc = pc;
        r.ill = ill; r.merr = merr; r.rdy = rdy; r.rc = m_retire;
        q.push_back(r);
        if (pc) m_retire = m_retire + 4'd1;
    endtask

    // Expected cycle-by-cycle outputs from the capture cycle to the last busy cycle.
    // k = MEM cycle carrying mem_done (0 = never).
    task automatic build(input logic [4:0] op, input int k, output int len);
        int          b;
        int          n;
        bit          done;
        logic [10:0] v;
        b = bit_of(op);
        v = (b >= 0) ? (11'd1 << b) : 11'd0;
        push(0, 11'd0, 0, 0, 0, 0, 1);
        if (b < 0) begin
            push(1, 11'd0, 0, 0, 1, 0, 0);
        end else begin
            push(1, v, 0, 0, 0, 0, 0);
            if (b == 0 || b == 1) begin
                push(2, v, 0, 0, 0, 0, 0);
                done = (k >= 1 && k <= T);
                n = done ? k : T;
                for (int i = 1; i <= n; i++)
                    push(3, v, 0, (i == n) && done && (b == 1), 0, (i == n) && !done, 0);
                if (done && b == 0) push(4, v, 1, 1, 0, 0, 0);
            end else if (b == 2 || b == 3 || b == 6 || b == 10) begin
                push(2, v, 0, 0, 0, 0, 0);
                push(4, v, 1, 1, 0, 0, 0);
            end else begin
                push(2, v, 0, 1, 0, 0, 0);
            end
        end
        len = q.size();
    endtask

    // Entered and left at posedge+1 of an IDLE cycle.
    task automatic issue(input logic [4:0] op, input int k, input bit hold, input bit stray);
        int len;
        build(op, k, len);
        instr_valid = 1'b1;
        opcode      = op;
        for (int c = 1; c < len; c++) begin
            @(posedge clock); #1;
            instr_valid = hold && (c < len - 1);
            mem_done    = (k > 0 && c == 2 + k) || (stray && (c == 1 || c == 2));
        end
        @(posedge clock); #1;
        instr_valid = 1'b0;
        mem_done    = 1'b0;
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            rec_t e;
            if (q.size() > 0) begin
                e = q.pop_front();
            end else begin
                e.st = 3'd0; e.ctrl = 11'd0; e.rf = 0; e.pc = 0; e.ill = 0;
                e.merr = 0; e.rdy = 1; e.rc = m_retire;
            end
            chk("state",       32'(state),       32'(e.st));
            chk("ctrl",        32'(ctrl),        32'(e.ctrl));
            chk("rf_we",       32'(rf_we),       32'(e.rf));
            chk("pc_we",       32'(pc_we),       32'(e.pc));
            chk("illegal",     32'(illegal),     32'(e.ill));
            chk("mem_err",     32'(mem_err),     32'(e.merr));
            chk("instr_ready", 32'(instr_ready), 32'(e.rdy));
            chk("retire_cnt",  32'(retire_cnt),  32'(e.rc));
        end
    end

    logic [4:0] all_ops[11] = '{5'h00, 5'h05, 5'h07, 5'h08, 5'h01, 5'h02,
                                5'h03, 5'h04, 5'h06, 5'h16, 5'h15};

    initial begin
        int len;
        n_run = 0; n_fail = 0; chk_en = 0; m_retire = 4'd0;
        reset = 1'b0; instr_valid = 1'b0; opcode = 5'h00; mem_done = 1'b0;
        #2;
        chk("rst_state",  32'(state),      32'd0);
        chk("rst_ctrl",   32'(ctrl),       32'd0);
        chk("rst_pc_we",  32'(pc_we),      32'd0);
        chk("rst_retire", 32'(retire_cnt), 32'd0);
        chk("model_bex",  32'(bit_of(5'h16)), 32'd9);
        chk("model_ill",  32'(bit_of(5'h1F)), 32'hFFFF_FFFF);
        @(posedge clock); @(posedge clock); #2;
        reset = 1'b1;
        @(posedge clock); #1;
        chk_en = 1;
        chk("ready_after_rst", 32'(instr_ready), 32'd1);

        for (int i = 0; i < 16; i++) begin
            issue(5'h01, 0, 0, 0);
            if (i == 0)  chk("retire_j1",  32'(retire_cnt), 32'd1);
            if (i == 14) chk("retire_j15", 32'(retire_cnt), 32'd15);
        end
        chk("retire_wrap", 32'(retire_cnt), 32'd0);

        issue(5'h00, 0, 1, 0);
        chk("retire_add", 32'(retire_cnt), 32'd1);
        issue(5'h08, 4, 0, 0);
        chk("retire_lw4", 32'(retire_cnt), 32'd2);
        issue(5'h07, 0, 0, 0);
        chk("retire_sw_to", 32'(retire_cnt), 32'd2);
        issue(5'h1F, 0, 1, 1);
        chk("retire_ill", 32'(retire_cnt), 32'd2);
        issue(5'h08, 0, 1, 0);
        issue(5'h08, 15, 0, 0);
        issue(5'h07, 1, 0, 0);
        issue(5'h07, 15, 1, 0);
        issue(5'h08, 1, 0, 0);
        chk("retire_mem", 32'(retire_cnt), 32'd6);
        for (int i = 0; i < 11; i++) issue(all_ops[i], 3, (i % 2) == 1, 0);
        chk("retire_all", 32'(retire_cnt), 32'd1);
        issue(5'h09, 0, 0, 1);
        issue(5'h17, 0, 0, 0);
        issue(5'h10, 0, 0, 0);
        issue(5'h15, 0, 0, 1);
        chk("retire_stray", 32'(retire_cnt), 32'd2);

        build(5'h08, 0, len);
        instr_valid = 1'b1; opcode = 5'h08;
        @(posedge clock); #1; instr_valid = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("mid_state", 32'(state), 32'd3);
        chk("mid_ctrl",  32'(ctrl),  32'h001);
        #2;
        reset = 1'b0;
        q.delete();
        m_retire = 4'd0;
        #1;
        chk("arst_state",   32'(state),      32'd0);
        chk("arst_ctrl",    32'(ctrl),       32'd0);
        chk("arst_rf_we",   32'(rf_we),      32'd0);
        chk("arst_pc_we",   32'(pc_we),      32'd0);
        chk("arst_illegal", 32'(illegal),    32'd0);
        chk("arst_mem_err", 32'(mem_err),    32'd0);
        chk("arst_retire",  32'(retire_cnt), 32'd0);
        @(posedge clock); @(posedge clock); #2;
        reset = 1'b1;
        @(posedge clock); #1;
        chk("rel_state", 32'(state), 32'd0);
        issue(5'h16, 0, 0, 0);
        chk("retire_bex", 32'(retire_cnt), 32'd1);
        issue(5'h08, 2, 0, 0);

        @(negedge clock); #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_fsm.md
CTRL_FSM -- requirements
Module: ctrl_fsm

Interface
REQ-001 Parameter OPCODE_W, default 5, SHALL be the opcode field width; opcodes are zero-extended to it.
REQ-002 Parameter CTRL_W, default 11, SHALL be the one-hot control vector width, minimum 11.
REQ-003 Parameter MEM_TIMEOUT, default 15, SHALL be the maximum cycles spent waiting in MEM.
REQ-004 Parameter CNT_W, default 16, SHALL be the retire counter width.
REQ-005 clock  in  1  sole clock; all state SHALL update on the rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 instr_valid  in  1  opcode on opcode is valid.
REQ-008 instr_ready  out  1  block accepts an opcode this cycle.
REQ-009 opcode  in  OPCODE_W  instruction opcode.
REQ-010 mem_done  in  1  data memory finished the current access.
REQ-011 ctrl  out  CTRL_W  registered one-hot control vector for the instruction in flight.
REQ-012 state  out  3  current state: IDLE=0, DECODE=1, EXEC=2, MEM=3, WB=4.
REQ-013 rf_we  out  1  register-file write strobe.
REQ-014 pc_we  out  1  PC update strobe, one per retired instruction.
REQ-015 illegal  out  1  one-cycle pulse on an undecodable opcode.
REQ-016 mem_err  out  1  one-cycle pulse on memory timeout.
REQ-017 retire_cnt  out  CNT_W  count of retired instructions.

Function
REQ-018 Decode SHALL map opcode to ctrl bit: add 0x00->3, addi 0x05->2, sw 0x07->1, lw 0x08->0, j 0x01->4, bne 0x02->5, jal 0x03->6, jr 0x04->7, blt 0x06->8, bex 0x16->9, setx 0x15->10; ctrl bits above 10 SHALL stay 0.
REQ-019 instr_ready SHALL be 1 only in IDLE; a capture SHALL occur only when instr_valid and instr_ready are both 1.
REQ-020 IDLE SHALL go to DECODE on capture; otherwise IDLE SHALL hold, with ctrl=0.
REQ-021 DECODE SHALL load ctrl with the decoded one-hot vector and go to EXEC; an unlisted opcode SHALL pulse illegal, leave ctrl=0, and go to IDLE without pc_we or a retire.
REQ-022 EXEC (1 cycle): lw/sw SHALL go to MEM; add/addi/jal/setx SHALL go to WB; j/bne/jr/blt/bex SHALL go to IDLE, asserting pc_we in EXEC.
REQ-023 MEM SHALL hold until mem_done=1; then lw SHALL go to WB, and sw SHALL assert pc_we and go to IDLE.
REQ-024 A wait counter SHALL clear on MEM entry; if MEM_TIMEOUT cycles elapse without mem_done, the block SHALL pulse mem_err, clear ctrl, and go to IDLE without pc_we or a retire.
REQ-025 mem_done and a timeout in the same cycle SHALL be treated as mem_done.
REQ-026 WB SHALL assert rf_we and pc_we for exactly 1 cycle, then go to IDLE.
REQ-027 ctrl SHALL hold its value from DECODE until the return to IDLE, then clear to 0.
REQ-028 retire_cnt SHALL increment by 1 on every pc_we cycle and wrap modulo 2^CNT_W.
REQ-029 mem_done outside MEM, and instr_valid outside IDLE, SHALL be ignored.
REQ-030 Latencies from capture to pc_we SHALL be: branch/jump 2 cycles, ALU/jal/setx 3 cycles, lw 3+N cycles, sw 2+N cycles, where N is the number of MEM cycles.

Reset
REQ-031 reset=0 SHALL immediately force state=IDLE, ctrl=0, rf_we=0, pc_we=0, illegal=0, mem_err=0, retire_cnt=0, and clear the wait counter; instr_ready SHALL be 1 after release.
REQ-032 reset asserted mid-instruction SHALL abandon it with no retire; the first edge after release SHALL be evaluated in IDLE.

Verification
REQ-033 add (0x00) accepted -> ctrl=0x008 from DECODE; rf_we and pc_we high on cycle 3; retire_cnt 0->1.
REQ-034 lw (0x08), mem_done on the 4th MEM cycle -> MEM lasts 4 cycles, then WB with rf_we=1; ctrl=0x001 throughout.
REQ-035 sw (0x07), mem_done never asserted, MEM_TIMEOUT=15 -> mem_err pulses after 15 MEM cycles; state=IDLE; retire_cnt unchanged.
REQ-036 opcode 0x1F -> illegal pulses in DECODE, ctrl stays 0, next cycle IDLE; instr_valid held high during busy states is not captured.
REQ-037 CNT_W=4, 16 back-to-back j (0x01) -> retire_cnt wraps to 0; each j shows ctrl=0x010.
REQ-038 reset low during MEM of lw -> all outputs are at reset values in that cycle; after release a bex (0x16) completes normally with ctrl=0x200.
